// File: rtl/vga_cell_timing_gen.sv
// Raster and character-cell timing generator: sync, visible/window flags and cell coordinates.
// Optional VGA_CELL_GENLOCK_EN enables the genlock input (force raster to pixel 0, line 0).
module vga_cell_timing_gen #(
   parameter int H_TOTAL  = 528,
   parameter int H_VIS    = 400,
   parameter int HS_START = 419,
   parameter int HS_END   = 483,
   parameter int V_TOTAL  = 628,
   parameter int V_VIS    = 600,
   parameter int VS_START = 600,
   parameter int VS_END   = 604,
   parameter bit SYNC_POL = 1'b0,
   parameter int CELL_W   = 6,
   parameter int CELL_H   = 12,
   parameter int LINE_REP = 3,
   parameter int COLS     = 64,
   parameter int ROWS     = 16,
   parameter int H_OFS    = 8,
   parameter int V_OFS    = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_ce,
   input  logic       mode_dbl,
   input  logic       genlock,
   output logic       hsync,
   output logic       vsync,
   output logic       vis,
   output logic       dsp_act,
   output logic [6:0] col,
   output logic [3:0] xpix,
   output logic [4:0] row,
   output logic [3:0] ypix,
   output logic       frame_stb,
   output logic       vblank,
   output logic       mode_act
);

   localparam int HW        = $clog2(H_TOTAL + 1);
   localparam int VW        = $clog2(V_TOTAL + 1);
   localparam int RW        = (LINE_REP > 1) ? $clog2(LINE_REP) : 1;
   localparam int WIN_H_END = H_OFS + COLS * CELL_W;
   localparam int WIN_V_END = V_OFS + ROWS * CELL_H * LINE_REP;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] HS_A   = HW'(HS_START);
   localparam logic [HW-1:0] HS_B   = HW'(HS_END);
   localparam logic [HW-1:0] HV_C   = HW'(H_VIS);
   localparam logic [HW-1:0] WH_A   = HW'(H_OFS);
   localparam logic [HW-1:0] WH_B   = HW'(WIN_H_END);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] VS_A   = VW'(VS_START);
   localparam logic [VW-1:0] VS_B   = VW'(VS_END);
   localparam logic [VW-1:0] VV_C   = VW'(V_VIS);
   localparam logic [VW-1:0] WV_A   = VW'(V_OFS);
   localparam logic [VW-1:0] WV_B   = VW'(WIN_V_END);
   localparam logic [3:0]    XP_LAST = 4'(CELL_W - 1);
   localparam logic [3:0]    YP_LAST = 4'(CELL_H - 1);
   localparam logic [RW-1:0] R_LAST  = RW'(LINE_REP - 1);

   if (HS_END > H_TOTAL) begin : g_chk_hs
      $error("HS_END exceeds H_TOTAL");
   end
   if (VS_END > V_TOTAL) begin : g_chk_vs
      $error("VS_END exceeds V_TOTAL");
   end
   if (WIN_H_END > H_VIS) begin : g_chk_wh
      $error("character window exceeds visible width");
   end
   if (WIN_V_END > V_VIS) begin : g_chk_wv
      $error("character window exceeds visible height");
   end
   if (COLS % 2 != 0) begin : g_chk_cols
      $error("COLS must be even");
   end

   logic glk;
`ifdef VGA_CELL_GENLOCK_EN
   assign glk = genlock;
`else
   assign glk = 1'b0;
   logic unused_genlock;
   assign unused_genlock = genlock;
`endif

   logic [HW-1:0] h_cnt, nh;
   logic [VW-1:0] v_cnt, nv;
   logic [RW-1:0] rep;
   logic          started, half;
   logic          line_adv, wrap, h_in_win, v_in_win, frame_mode;

   // The counters hold the position currently on the outputs; nh/nv is the position being entered.
   always_comb begin
      nh       = h_cnt;
      nv       = v_cnt;
      line_adv = 1'b0;
      wrap     = 1'b0;
      if (glk || !started) begin
         nh = '0;
         nv = '0;
      end else if (h_cnt == H_LAST) begin
         nh       = '0;
         line_adv = 1'b1;
         if (v_cnt == V_LAST) begin
            nv   = '0;
            wrap = 1'b1;
         end else begin
            nv = v_cnt + 1'b1;
         end
      end else begin
         nh = h_cnt + 1'b1;
      end
      h_in_win   = (nh >= WH_A) && (nh < WH_B);
      v_in_win   = (nv >= WV_A) && (nv < WV_B);
      frame_mode = (glk || wrap) ? mode_dbl : mode_act;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt     <= '0;
         v_cnt     <= '0;
         started   <= 1'b0;
         rep       <= '0;
         half      <= 1'b0;
         col       <= '0;
         xpix      <= '0;
         row       <= '0;
         ypix      <= '0;
         hsync     <= ~SYNC_POL;
         vsync     <= ~SYNC_POL;
         vis       <= 1'b0;
         dsp_act   <= 1'b0;
         frame_stb <= 1'b0;
         vblank    <= 1'b0;
         mode_act  <= 1'b0;
      end else if (glk || pix_ce) begin
         // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
         h_cnt     <= nh;
         v_cnt     <= nv;
         started   <= 1'b1;
         hsync     <= (nh >= HS_A && nh < HS_B) ? SYNC_POL : ~SYNC_POL;
         vsync     <= (nv >= VS_A && nv < VS_B) ? SYNC_POL : ~SYNC_POL;
         vis       <= (nh < HV_C) && (nv < VV_C);
         vblank    <= (nv >= VV_C);
         dsp_act   <= h_in_win && v_in_win;
         frame_stb <= wrap;
         mode_act  <= frame_mode;
         if (glk) begin
            rep  <= '0;
            half <= 1'b0;
            col  <= '0;
            xpix <= '0;
            row  <= '0;
            ypix <= '0;
         end else begin
            // Scan rows advance on each new window line after the first; the frame wrap restarts them.
            if (wrap) begin
               rep  <= '0;
               row  <= '0;
               ypix <= '0;
            end else if (line_adv && v_in_win && nv != WV_A) begin
               if (rep == R_LAST) begin
                  rep <= '0;
                  if (ypix == YP_LAST) begin
                     ypix <= '0;
                     row  <= row + 1'b1;
                  end else begin
                     ypix <= ypix + 1'b1;
                  end
               end else begin
                  rep <= rep + 1'b1;
               end
            end
            if (h_in_win && v_in_win) begin
               if (nh == WH_A) begin
                  col  <= '0;
                  xpix <= '0;
                  half <= 1'b0;
               end else if (frame_mode && !half) begin
                  half <= 1'b1;
               end else begin
                  half <= 1'b0;
                  if (xpix == XP_LAST) begin
                     xpix <= '0;
                     col  <= col + 1'b1;
                  end else begin
                     xpix <= xpix + 1'b1;
                  end
               end
            end
         end
      end else begin
         frame_stb <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_cell_timing_gen.sv
// Randomized bench: small-raster DUT checked every cycle against an arithmetic model,
// plus a default-parameter DUT pinned with hand-computed literal expectations.
module tb_vga_cell_timing_gen;

   localparam int HT = 40, HV = 32, HSS = 34, HSE = 37;
   localparam int VT = 30, VV = 26, VSS = 27, VSE = 29;
   localparam int CW = 3, CH = 2, LR = 2, NC = 8, NR = 5, HO = 4, VO = 3;
   localparam int WHE = HO + NC * CW;
   localparam int WVE = VO + NR * CH * LR;

   logic clk = 1'b0;
   logic rst_n = 1'b0, pix_ce = 1'b0, mode_dbl = 1'b0, genlock = 1'b0;
   logic hsync, vsync, vis, dsp_act, frame_stb, vblank, mode_act;
   logic [6:0] col;
   logic [3:0] xpix, ypix;
   logic [4:0] row;

   logic rst_n_d = 1'b0, pix_ce_d = 1'b1, mode_dbl_d = 1'b0, genlock_d = 1'b0;
   logic hsync_d, vsync_d, vis_d, dsp_act_d, frame_stb_d, vblank_d, mode_act_d;
   logic [6:0] col_d;
   logic [3:0] xpix_d, ypix_d;
   logic [4:0] row_d;

   vga_cell_timing_gen #(
      .H_TOTAL(HT), .H_VIS(HV), .HS_START(HSS), .HS_END(HSE),
      .V_TOTAL(VT), .V_VIS(VV), .VS_START(VSS), .VS_END(VSE), .SYNC_POL(1'b0),
      .CELL_W(CW), .CELL_H(CH), .LINE_REP(LR), .COLS(NC), .ROWS(NR), .H_OFS(HO), .V_OFS(VO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .mode_dbl(mode_dbl), .genlock(genlock),
      .hsync(hsync), .vsync(vsync), .vis(vis), .dsp_act(dsp_act), .col(col), .xpix(xpix),
      .row(row), .ypix(ypix), .frame_stb(frame_stb), .vblank(vblank), .mode_act(mode_act)
   );

   vga_cell_timing_gen dut_def (
      .clk(clk), .rst_n(rst_n_d), .pix_ce(pix_ce_d), .mode_dbl(mode_dbl_d), .genlock(genlock_d),
      .hsync(hsync_d), .vsync(vsync_d), .vis(vis_d), .dsp_act(dsp_act_d), .col(col_d), .xpix(xpix_d),
      .row(row_d), .ypix(ypix_d), .frame_stb(frame_stb_d), .vblank(vblank_d), .mode_act(mode_act_d)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         n_fail++;
         if (n_fail <= 25)
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: raster position as plain integers; outputs derived by division/modulo.
   bit m_started, m_mode, m_fstb;
   int m_h, m_v, m_col, m_xpix;

   task automatic model_reset();
      m_started = 1'b0;
      m_mode    = 1'b0;
      m_fstb    = 1'b0;
      m_h       = 0;
      m_v       = 0;
      m_col     = 0;
      m_xpix    = 0;
   endtask

   task automatic model_step(input bit ce, input bit md, input bit gl);
      int div;
      m_fstb = 1'b0;
`ifdef VGA_CELL_GENLOCK_EN
      if (gl) begin
         m_started = 1'b1;
         m_h = 0;
         m_v = 0;
         m_mode = md;
         m_col = 0;
         m_xpix = 0;
         return;
      end
`endif
      if (!ce) return;
      if (!m_started) begin
         m_started = 1'b1;
         m_h = 0;
         m_v = 0;
      end else begin
         m_h++;
         if (m_h == HT) begin
            m_h = 0;
            m_v++;
            if (m_v == VT) begin
               m_v    = 0;
               m_fstb = 1'b1;
               m_mode = md;
            end
         end
      end
      if (m_h >= HO && m_h < WHE && m_v >= VO && m_v < WVE) begin
         div    = m_mode ? 2 : 1;
         m_col  = (m_h - HO) / (CW * div);
         m_xpix = ((m_h - HO) / div) % CW;
      end
   endtask

   task automatic compare_all();
      int e_hs = 1, e_vs = 1, e_vis = 0, e_dsp = 0, e_vb = 0, e_row = 0, e_ypix = 0;
      int vv, s;
      if (m_started) begin
         e_hs  = (m_h >= HSS && m_h < HSE) ? 0 : 1;
         e_vs  = (m_v >= VSS && m_v < VSE) ? 0 : 1;
         e_vis = (m_h < HV && m_v < VV) ? 1 : 0;
         e_vb  = (m_v >= VV) ? 1 : 0;
         e_dsp = (m_h >= HO && m_h < WHE && m_v >= VO && m_v < WVE) ? 1 : 0;
         if (m_v >= VO) begin
            vv     = (m_v < WVE) ? m_v : WVE - 1;
            s      = (vv - VO) / LR;
            e_row  = s / CH;
            e_ypix = s % CH;
         end
      end
      check("hsync", hsync, e_hs);
      check("vsync", vsync, e_vs);
      check("vis", vis, e_vis);
      check("vblank", vblank, e_vb);
      check("dsp_act", dsp_act, e_dsp);
      check("col", col, m_col);
      check("xpix", xpix, m_xpix);
      check("row", row, e_row);
      check("ypix", ypix, e_ypix);
      check("frame_stb", frame_stb, m_fstb);
      check("mode_act", mode_act, m_mode);
   endtask

   task automatic drive_cycle(input bit ce, input bit md, input bit gl);
      @(negedge clk);
      pix_ce   = ce;
      mode_dbl = md;
      genlock  = gl;
      @(posedge clk);
      #1;
      model_step(ce, md, gl);
      compare_all();
   endtask

   // Default-parameter instance: position after n ticks is n-1 in raster order.
   int  d_ticks = 0;
   bit  lit_done = 1'b0;
   always @(posedge clk) if (rst_n_d) d_ticks <= d_ticks + 1;

   task automatic at_pos(input int h, input int v);
      int target = v * 528 + h + 1;
      int guard  = 0;
      while (d_ticks < target && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20000) check("def_wait_timeout", 0, 1);
   endtask

   initial begin
      wait (rst_n_d === 1'b1);
      at_pos(0, 0);
      check("def_h0_hsync", hsync_d, 1);
      check("def_h0_vsync", vsync_d, 1);
      check("def_h0_vis", vis_d, 1);
      check("def_h0_fstb", frame_stb_d, 0);
      at_pos(399, 0);  check("def_h399_vis", vis_d, 1);
      at_pos(400, 0);  check("def_h400_vis", vis_d, 0);
      at_pos(418, 0);  check("def_h418_hsync", hsync_d, 1);
      at_pos(419, 0);  check("def_h419_hsync", hsync_d, 0);
      at_pos(482, 0);  check("def_h482_hsync", hsync_d, 0);
      at_pos(483, 0);  check("def_h483_hsync", hsync_d, 1);
      at_pos(8, 12);
      check("def_win_dsp", dsp_act_d, 1);
      check("def_win_col", col_d, 0);
      check("def_win_xpix", xpix_d, 0);
      check("def_win_row", row_d, 0);
      check("def_win_ypix", ypix_d, 0);
      at_pos(391, 12);
      check("def_h391_dsp", dsp_act_d, 1);
      check("def_h391_col", col_d, 63);
      check("def_h391_xpix", xpix_d, 5);
      at_pos(392, 12);
      check("def_h392_dsp", dsp_act_d, 0);
      check("def_h392_col", col_d, 63);
      at_pos(8, 14);
      check("def_v14_ypix", ypix_d, 0);
      check("def_v14_row", row_d, 0);
      at_pos(8, 15);
      check("def_v15_ypix", ypix_d, 1);
      check("def_v15_vsync", vsync_d, 1);
      lit_done = 1'b1;
   end

   initial begin
      int guard, period;
      model_reset();
      #12;
      compare_all();
      check("rst_hsync", hsync, 1);
      check("rst_vis", vis, 0);
      @(negedge clk);
      rst_n   = 1'b1;
      rst_n_d = 1'b1;

      for (int i = 0; i < 6000; i++)
         drive_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);

      for (int i = 0; i < 3000; i++)
         drive_cycle(i % 2 == 0, 1'b1, 1'b0);

      // Period between frame strobes with pix_ce held high.
      guard = 0;
      while (!frame_stb && guard < 2500) begin
         drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
         guard++;
      end
      period = 0;
      do begin
         drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
         period++;
      end while (!frame_stb && period < 2500);
      check("frame_period", period, HT * VT);

      // Asynchronous reset in the middle of a line.
      repeat (57) drive_cycle(1'b1, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      check("midrst_hsync", hsync, 1);
      check("midrst_mode", mode_act, 0);
      @(negedge clk);
      pix_ce = 1'b0;
      rst_n  = 1'b1;
      drive_cycle(1'b1, 1'b0, 1'b0);
      check("post_rst_fstb", frame_stb, 0);
      check("post_rst_vis", vis, 1);
      check("post_rst_dsp", dsp_act, 0);

      for (int i = 0; i < 2500; i++)
         drive_cycle($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);

      guard = 0;
      while (!lit_done && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (!lit_done) check("def_literals_done", 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
